// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between two requesters through an IDLE/MEM/ACK sequencer.
// Optional feature macro DMEM_ARB_RR_EN: round-robin tie-break; when undefined, port 0 has fixed priority.
module dmem_arbiter #(
  parameter int ADDR_BITS = 6,
  parameter int DATA_BITS = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 we0,
  input  logic [ADDR_BITS-1:0] addr0,
  input  logic [DATA_BITS-1:0] wdata0,
  input  logic                 req1,
  input  logic                 we1,
  input  logic [ADDR_BITS-1:0] addr1,
  input  logic [DATA_BITS-1:0] wdata1,
  output logic                 ack0,
  output logic [DATA_BITS-1:0] rdata0,
  output logic                 ack1,
  output logic [DATA_BITS-1:0] rdata1,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_we,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic [DATA_BITS-1:0] mem_rdata,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   winner;   // port owning the access in flight: 0 or 1
  logic   any_req;
  logic   grant1;   // arbitration result, meaningful only in IDLE

  assign any_req = req0 | req1;

`ifdef DMEM_ARB_RR_EN
  logic last;       // port granted most recently; the other one wins a tie

  assign grant1 = req1 & (~req0 | ~last);

  always_ff @(posedge clk) begin
    if (rst)
      last <= 1'b1;
    else if (state == ST_IDLE && any_req)
      last <= grant1;
  end
`else
  assign grant1 = req1 & ~req0;
`endif

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  // NOTE: default assignment first, so no path through the case leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (any_req) state_next = ST_MEM;
      ST_MEM:  state_next = ST_ACK;
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Memory-side registers and per-port read data; requester inputs are only looked at in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      winner    <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            winner    <= grant1;
            mem_addr  <= grant1 ? addr1  : addr0;
            mem_we    <= grant1 ? we1    : we0;
            mem_wdata <= grant1 ? wdata1 : wdata0;
          end
        end
        ST_MEM: begin
          mem_we <= 1'b0;
          if (!mem_we) begin
            if (winner)
              rdata1 <= mem_rdata;
            else
              rdata0 <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Acks are cut as soon as reset is seen so a reset in ACK never completes the handshake.
  always_comb begin
    busy = 1'b0;
    ack0 = 1'b0;
    ack1 = 1'b0;
    case (state)
      ST_MEM: busy = 1'b1;
      ST_ACK: begin
        busy = 1'b1;
        ack0 = ~rst & ~winner;
        ack1 = ~rst &  winner;
      end
      default: ;
    endcase
  end

  ap_we_only_in_mem: assert property (@(posedge clk) disable iff (rst) mem_we |-> (state == ST_MEM));
  ap_acks_exclusive: assert property (@(posedge clk) !(ack0 && ack1));

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus a randomized run checked against a transaction-level scheduling model.
module tb_dmem_arbiter;

  localparam int AW = 6;
  localparam int DW = 64;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1, mem_addr;
  logic [DW-1:0] wdata0, wdata1, rdata0, rdata1, mem_wdata, mem_rdata;
  logic          ack0, ack1, mem_we, busy;

  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int total = 0;
  int bad   = 0;

  assign mem_rdata = mem[mem_addr];

  dmem_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .rdata0(rdata0), .ack1(ack1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // The memory commits mid-cycle from the registered mem_we, equivalent to committing at the closing edge.
  task automatic tick();
    @(negedge clk);
    if (mem_we) mem[mem_addr] = mem_wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      rst = 1'b1;
      req0 = 1'($urandom_range(0, 1)); req1 = 1'($urandom_range(0, 1));
      we0 = 1'($urandom_range(0, 1));  we1 = 1'($urandom_range(0, 1));
      addr0 = AW'($urandom); addr1 = AW'($urandom);
      wdata0 = {$urandom, $urandom}; wdata1 = {$urandom, $urandom};
      tick();
      total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL rst_ack0 c=%0d got=%0b exp=0", c, ack0); end
      total++; if (ack1 !== 1'b0) begin bad++; $display("FAIL rst_ack1 c=%0d got=%0b exp=0", c, ack1); end
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we c=%0d got=%0b exp=0", c, mem_we); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy c=%0d got=%0b exp=0", c, busy); end
      total++; if (mem_addr !== '0) begin bad++; $display("FAIL rst_mem_addr c=%0d got=%h exp=0", c, mem_addr); end
      total++; if (mem_wdata !== '0) begin bad++; $display("FAIL rst_mem_wdata c=%0d got=%h exp=0", c, mem_wdata); end
      total++; if (rdata0 !== '0) begin bad++; $display("FAIL rst_rdata0 c=%0d got=%h exp=0", c, rdata0); end
      total++; if (rdata1 !== '0) begin bad++; $display("FAIL rst_rdata1 c=%0d got=%h exp=0", c, rdata1); end
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_single_read();
    mem[5] = 64'hDEAD_BEEF_0000_0001;
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'd5; wdata0 = {$urandom, $urandom};
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rd_busy_c0 got=%0b exp=0", busy); end
    tick();
    total++; if (mem_addr !== 6'd5) begin bad++; $display("FAIL rd_mem_addr got=%0d exp=5", mem_addr); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rd_mem_we got=%0b exp=0", mem_we); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rd_busy_c1 got=%0b exp=1", busy); end
    total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL rd_ack0_c1 got=%0b exp=0", ack0); end
    tick();
    total++; if (ack0 !== 1'b1) begin bad++; $display("FAIL rd_ack0_c2 got=%0b exp=1", ack0); end
    total++; if (rdata0 !== 64'hDEAD_BEEF_0000_0001) begin bad++; $display("FAIL rd_rdata0 got=%h exp=deadbeef00000001", rdata0); end
    total++; if (ack1 !== 1'b0) begin bad++; $display("FAIL rd_ack1 got=%0b exp=0", ack1); end
    tick();
    req0 = 1'b0;
    total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL rd_ack0_c3 got=%0b exp=0", ack0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rd_busy_c3 got=%0b exp=0", busy); end
  endtask

  task automatic test_single_write();
    mem[9] = '0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 6'd9; wdata1 = 64'h1234;
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL wr_mem_we_c0 got=%0b exp=0", mem_we); end
    tick();
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL wr_mem_we_c1 got=%0b exp=1", mem_we); end
    total++; if (mem_addr !== 6'd9) begin bad++; $display("FAIL wr_mem_addr got=%0d exp=9", mem_addr); end
    total++; if (mem_wdata !== 64'h1234) begin bad++; $display("FAIL wr_mem_wdata got=%h exp=1234", mem_wdata); end
    total++; if (ack1 !== 1'b0) begin bad++; $display("FAIL wr_ack1_c1 got=%0b exp=0", ack1); end
    tick();
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL wr_mem_we_c2 got=%0b exp=0", mem_we); end
    total++; if (ack1 !== 1'b1) begin bad++; $display("FAIL wr_ack1_c2 got=%0b exp=1", ack1); end
    total++; if (rdata1 !== '0) begin bad++; $display("FAIL wr_rdata1_kept got=%h exp=0", rdata1); end
    total++; if (rdata0 !== 64'hDEAD_BEEF_0000_0001) begin bad++; $display("FAIL wr_rdata0_kept got=%h exp=deadbeef00000001", rdata0); end
    tick();
    req1 = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'd9;
    total++; if (mem[9] !== 64'h1234) begin bad++; $display("FAIL wr_mem_word9 got=%h exp=1234", mem[9]); end
    tick();
    tick();
    total++; if (ack0 !== 1'b1) begin bad++; $display("FAIL wr_readback_ack0 got=%0b exp=1", ack0); end
    total++; if (rdata0 !== 64'h1234) begin bad++; $display("FAIL wr_readback_rdata0 got=%h exp=1234", rdata0); end
    tick();
    req0 = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] v1, v2, e_r1;
    logic e_a0, e_a1;
    v1 = {$urandom, $urandom}; v2 = {$urandom, $urandom};
    mem[1] = v1; mem[2] = v2;
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 6'd2;
    for (int c = 0; c < 6; c++) begin
      e_a0 = (c == 2) || (!RR && c == 5);
      e_a1 = RR && (c == 5);
      e_r1 = (RR && c == 5) ? v2 : '0;
      total++; if (ack0 !== e_a0) begin bad++; $display("FAIL sim_ack0 c=%0d got=%0b exp=%0b", c, ack0, e_a0); end
      total++; if (ack1 !== e_a1) begin bad++; $display("FAIL sim_ack1 c=%0d got=%0b exp=%0b", c, ack1, e_a1); end
      total++; if (rdata1 !== e_r1) begin bad++; $display("FAIL sim_rdata1 c=%0d got=%h exp=%h", c, rdata1, e_r1); end
      if (c == 2) begin
        total++; if (rdata0 !== v1) begin bad++; $display("FAIL sim_rdata0 got=%h exp=%h", rdata0, v1); end
      end
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL sim_busy_end got=%0b exp=0", busy); end
  endtask

  task automatic test_reset_in_mem();
    mem[3] = '0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 6'd3; wdata0 = 64'hAA;
    tick();
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL rmem_mem_we_c1 got=%0b exp=1", mem_we); end
    rst = 1'b1; req0 = 1'b0;
    tick();
    rst = 1'b0;
    total++; if (mem[3] !== 64'hAA) begin bad++; $display("FAIL rmem_word3 got=%h exp=aa", mem[3]); end
    total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL rmem_ack0 got=%0b exp=0", ack0); end
    total++; if (ack1 !== 1'b0) begin bad++; $display("FAIL rmem_ack1 got=%0b exp=0", ack1); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmem_busy got=%0b exp=0", busy); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rmem_mem_we got=%0b exp=0", mem_we); end
    total++; if (mem_addr !== '0) begin bad++; $display("FAIL rmem_mem_addr got=%h exp=0", mem_addr); end
    total++; if (mem_wdata !== '0) begin bad++; $display("FAIL rmem_mem_wdata got=%h exp=0", mem_wdata); end
    total++; if (rdata0 !== '0) begin bad++; $display("FAIL rmem_rdata0 got=%h exp=0", rdata0); end
    total++; if (rdata1 !== '0) begin bad++; $display("FAIL rmem_rdata1 got=%h exp=0", rdata1); end
    for (int c = 3; c < 5; c++) begin
      tick();
      total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL rmem_no_ack c=%0d got=%0b exp=0", c, ack0); end
    end
  endtask

  task automatic test_late_request();
    logic [DW-1:0] v4, v6;
    v4 = {$urandom, $urandom}; v6 = {$urandom, $urandom};
    mem[4] = v4; mem[6] = v6;
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'd4;
    tick();
    req1 = 1'b1; we1 = 1'b0; addr1 = 6'd6; wdata1 = {$urandom, $urandom};
    total++; if (mem_addr !== 6'd4) begin bad++; $display("FAIL late_mem_addr_c1 got=%0d exp=4", mem_addr); end
    tick();
    total++; if (ack0 !== 1'b1) begin bad++; $display("FAIL late_ack0 got=%0b exp=1", ack0); end
    total++; if (rdata0 !== v4) begin bad++; $display("FAIL late_rdata0 got=%h exp=%h", rdata0, v4); end
    total++; if (mem_addr !== 6'd4) begin bad++; $display("FAIL late_mem_addr_c2 got=%0d exp=4", mem_addr); end
    total++; if (ack1 !== 1'b0) begin bad++; $display("FAIL late_ack1_c2 got=%0b exp=0", ack1); end
    tick();
    req0 = 1'b0;
    total++; if (mem_addr !== 6'd4) begin bad++; $display("FAIL late_mem_addr_c3 got=%0d exp=4", mem_addr); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL late_busy_c3 got=%0b exp=0", busy); end
    tick();
    total++; if (mem_addr !== 6'd6) begin bad++; $display("FAIL late_mem_addr_c4 got=%0d exp=6", mem_addr); end
    total++; if (ack1 !== 1'b0) begin bad++; $display("FAIL late_ack1_c4 got=%0b exp=0", ack1); end
    tick();
    total++; if (ack1 !== 1'b1) begin bad++; $display("FAIL late_ack1_c5 got=%0b exp=1", ack1); end
    total++; if (rdata1 !== v6) begin bad++; $display("FAIL late_rdata1 got=%h exp=%h", rdata1, v6); end
    tick();
    req1 = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL late_busy_c6 got=%0b exp=0", busy); end
  endtask

  // Scheduling model: a grant in cycle g occupies g+1 (memory) and g+2 (ack); the next grant is possible at g+3.
  task automatic test_random(input int n);
    bit            pend [2];
    bit            acked_prev [2];
    bit            e_ack [2];
    logic          we_p [2];
    logic [AW-1:0] ad_p [2];
    logic [DW-1:0] wd_p [2];
    logic [DW-1:0] e_rdata [2];
    logic [AW-1:0] e_maddr, g_addr;
    logic [DW-1:0] e_mwdata, g_wdata, g_rexp, v;
    bit            have_g, g_port, g_we, last_m, e_busy, e_mwe;
    int            g, next_free;
    do_reset();
    for (int i = 0; i < (1 << AW); i++) begin
      v = {$urandom, $urandom};
      mem[i] = v; ref_mem[i] = v;
    end
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; acked_prev[p] = 1'b0; e_rdata[p] = '0;
      we_p[p] = 1'b0; ad_p[p] = '0; wd_p[p] = '0;
    end
    e_maddr = '0; e_mwdata = '0; g_addr = '0; g_wdata = '0; g_rexp = '0;
    have_g = 1'b0; g_port = 1'b0; g_we = 1'b0; last_m = 1'b1; g = 0; next_free = 0;
    for (int t = 0; t < n; t++) begin
      for (int p = 0; p < 2; p++) begin
        if (acked_prev[p]) pend[p] = 1'b0;
        if (!pend[p] && t < n - 12 && $urandom_range(0, 2) == 0) begin
          pend[p] = 1'b1;
          we_p[p] = 1'($urandom_range(0, 1));
          ad_p[p] = AW'($urandom);
          wd_p[p] = {$urandom, $urandom};
        end
      end
      req0 = pend[0]; we0 = we_p[0]; addr0 = ad_p[0]; wdata0 = wd_p[0];
      req1 = pend[1]; we1 = we_p[1]; addr1 = ad_p[1]; wdata1 = wd_p[1];

      e_busy = have_g && (t == g + 1 || t == g + 2);
      e_mwe  = have_g && (t == g + 1) && g_we;
      if (have_g && t == g + 1) begin
        e_maddr = g_addr; e_mwdata = g_wdata;
      end
      for (int p = 0; p < 2; p++)
        e_ack[p] = have_g && (t == g + 2) && (int'(g_port) == p);
      if (have_g && t == g + 2 && !g_we) e_rdata[g_port] = g_rexp;

      total++; if (ack0 !== e_ack[0]) begin bad++; $display("FAIL rnd_ack0 t=%0d got=%0b exp=%0b", t, ack0, e_ack[0]); end
      total++; if (ack1 !== e_ack[1]) begin bad++; $display("FAIL rnd_ack1 t=%0d got=%0b exp=%0b", t, ack1, e_ack[1]); end
      total++; if (busy !== e_busy) begin bad++; $display("FAIL rnd_busy t=%0d got=%0b exp=%0b", t, busy, e_busy); end
      total++; if (mem_we !== e_mwe) begin bad++; $display("FAIL rnd_mem_we t=%0d got=%0b exp=%0b", t, mem_we, e_mwe); end
      total++; if (mem_addr !== e_maddr) begin bad++; $display("FAIL rnd_mem_addr t=%0d got=%h exp=%h", t, mem_addr, e_maddr); end
      total++; if (mem_wdata !== e_mwdata) begin bad++; $display("FAIL rnd_mem_wdata t=%0d got=%h exp=%h", t, mem_wdata, e_mwdata); end
      total++; if (rdata0 !== e_rdata[0]) begin bad++; $display("FAIL rnd_rdata0 t=%0d got=%h exp=%h", t, rdata0, e_rdata[0]); end
      total++; if (rdata1 !== e_rdata[1]) begin bad++; $display("FAIL rnd_rdata1 t=%0d got=%h exp=%h", t, rdata1, e_rdata[1]); end

      for (int p = 0; p < 2; p++) acked_prev[p] = e_ack[p];

      if (t >= next_free && (pend[0] || pend[1])) begin
        if (pend[0] && pend[1]) g_port = RR ? ~last_m : 1'b0;
        else                    g_port = pend[1];
        last_m = g_port; have_g = 1'b1; g = t; next_free = t + 3;
        g_we = we_p[g_port]; g_addr = ad_p[g_port]; g_wdata = wd_p[g_port];
        if (g_we) ref_mem[g_addr] = g_wdata;
        else      g_rexp = ref_mem[g_addr];
      end
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    test_reset();
    test_single_read();
    test_single_write();
    test_simultaneous();
    test_reset_in_mem();
    test_late_request();
    test_random(600);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the processor core's load/store port (port 0) and a secondary requester such as a debug loader or DMA engine (port 1). It sits between the requesters and the data memory. It serialises accesses through a three-state sequencer, registers every memory-side signal, and returns a one-cycle acknowledge with registered read data to the winning requester.

## Interface
- ADDR_BITS, 6, word address width on all ports
- DATA_BITS, 64, data width on all ports
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- req0 / req1  in  1  access request; held high with stable we/addr/wdata until ack
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_BITS  word address
- wdata0 / wdata1  in  DATA_BITS  write data
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  DATA_BITS  read data; valid in the ack cycle, held until the next ack on that port
- mem_addr  out  ADDR_BITS  registered memory address
- mem_we  out  1  registered memory write enable
- mem_wdata  out  DATA_BITS  registered memory write data
- mem_rdata  in  DATA_BITS  memory read data; combinational from mem_addr
- busy  out  1  high in the MEM and ACK states

## Operation
- Sequencer states: IDLE, MEM, ACK.
- IDLE:
  - No request: stay in IDLE.
  - One or more requests: arbitrate, latch the winner's addr/we/wdata into mem_addr/mem_we/mem_wdata, record the winner index, go to MEM.
- MEM: the memory sees the registered access.
  - A write commits at the end of this cycle.
  - For a read, mem_rdata is sampled into the winner's rdata register at the end of this cycle.
  - mem_we clears at the end of MEM.
  - Always go to ACK.
- ACK: the winner's ack is high for exactly one cycle, then the sequencer returns to IDLE.
- The requester drops req, or presents a new request, in the cycle after ack. A req still high in the ACK cycle is ignored.
- Arbitration runs only in IDLE:
  - Only one req high: that port wins.
  - Both req high: the port not granted most recently wins (round-robin pointer `last`, updated on every grant).
- mem_we is high only in MEM, and only for a write grant. mem_addr and mem_wdata hold their last value outside MEM.
- The non-winning rdata is unchanged. A write grant leaves the winner's rdata unchanged.
- The non-winning port's req is held pending and is serviced at the next IDLE.

## Timing
- Latency: req high in cycle N (sequencer in IDLE) -> MEM in N+1 -> ack and rdata valid in N+2.
- Throughput: one access per 3 cycles. Back-to-back alternating service when both ports hold req.
- Worst-case wait for a port with req held: 3 cycles after the other port's ack (round-robin).
- Reset values: state IDLE, ack0 = ack1 = 0, rdata0 = rdata1 = 0, mem_addr = 0, mem_we = 0, mem_wdata = 0, busy = 0, last = 1 (port 0 wins the first tie).
- Reset asserted during MEM:
  - A write already presented completes in memory on that edge.
  - No ack is issued.
  - All state returns to reset values.
- Reset during ACK: the ack is cut; outputs are at reset values in the next cycle.
- A req that rises while the sequencer is in MEM or ACK waits for IDLE. There is no combinational path from req to mem_*.
- Requester inputs change while their req is held and un-acked: undefined behaviour. Inputs are sampled only in IDLE.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin tie-break as above.
- DMEM_ARB_RR_EN undefined: fixed priority.
  - Port 0 always wins a tie; `last` is not implemented.
  - Port 1 can be starved by continuous port-0 requests.
  - All other behaviour and timing are identical.

## Test plan
- Single read: after reset, memory word 5 = 64'hDEAD_BEEF_0000_0001. req0 = 1, we0 = 0, addr0 = 5 at cycle 0 -> mem_addr = 5 and mem_we = 0 in cycle 1; ack0 = 1 and rdata0 = 64'hDEAD_BEEF_0000_0001 in cycle 2; ack1 stays 0.
- Single write: req1 = 1, we1 = 1, addr1 = 9, wdata1 = 64'h1234 -> mem_we = 1 for exactly one cycle with mem_addr = 9 and mem_wdata = 64'h1234; ack1 two cycles after req. A following port-0 read of addr 9 returns 64'h1234.
- Simultaneous requests, RR build: req0 and req1 both held for 6 cycles -> port 0 acked at cycle 2, port 1 at cycle 5. Without DMEM_ARB_RR_EN: port 0 acked at cycles 2 and 5 while req0 stays high; port 1 never acked.
- Reset during MEM of a write (addr 3, data 64'hAA): rst = 1 in cycle 1 -> memory word 3 = 64'hAA, no ack, and in cycle 2 all outputs are at reset values with busy = 0.
- Late request: req1 rises while port 0 is in MEM -> mem_* unchanged until port 0's ack; port 1 enters MEM the cycle after the following IDLE; ack1 arrives 3 cycles after ack0.
- Reset values: hold rst = 1 for 2 cycles with random req inputs -> ack0, ack1, mem_we and busy stay 0; mem_addr, mem_wdata, rdata0 and rdata1 stay 0.
